// File: rtl/computer_top.sv
// SAP-2 style 8-bit computer: multicycle CPU with a 4-cycle-per-byte fetch, 4 KiB RAM at 0x0000, 4 KiB boot ROM at 0xF000.
// No external I/O; programs are loaded through the memory sim tasks and state is observed hierarchically.
package arch_defs_pkg;
   localparam int unsigned DATA_WIDTH = 8;
   localparam int unsigned ADDR_WIDTH = 16;
   localparam int unsigned RAM_DEPTH  = 4096;
   localparam int unsigned ROM_DEPTH  = 4096;
   localparam logic [ADDR_WIDTH-1:0] ROM_BASE = 16'hF000;

   localparam logic [DATA_WIDTH-1:0] OP_LDI_A = 8'h3E, OP_LDI_B = 8'h06, OP_LDI_C = 8'h0E;
   localparam logic [DATA_WIDTH-1:0] OP_INR_A = 8'h3C, OP_INR_B = 8'h04, OP_INR_C = 8'h0C;
   localparam logic [DATA_WIDTH-1:0] OP_DCR_A = 8'h3D, OP_DCR_B = 8'h05, OP_DCR_C = 8'h0D;
   localparam logic [DATA_WIDTH-1:0] OP_MOV_AB = 8'h78, OP_MOV_AC = 8'h79, OP_MOV_BA = 8'h47;
   localparam logic [DATA_WIDTH-1:0] OP_MOV_BC = 8'h41, OP_MOV_CA = 8'h4F, OP_MOV_CB = 8'h48;
   localparam logic [DATA_WIDTH-1:0] OP_ADD_B = 8'h80, OP_ADD_C = 8'h81, OP_SUB_B = 8'h90, OP_SUB_C = 8'h91;
   localparam logic [DATA_WIDTH-1:0] OP_ANA_B = 8'hA0, OP_ANA_C = 8'hA1, OP_ORA_B = 8'hB0, OP_ORA_C = 8'hB1;
   localparam logic [DATA_WIDTH-1:0] OP_XRA_B = 8'hA8, OP_XRA_C = 8'hA9;
   localparam logic [DATA_WIDTH-1:0] OP_LDA = 8'h3A, OP_STA = 8'h32, OP_JMP = 8'hC3, OP_HLT = 8'h76;

   function automatic logic [1:0] op_bytes(input logic [DATA_WIDTH-1:0] op);
      case (op)
         OP_LDI_A, OP_LDI_B, OP_LDI_C: return 2'd2;
         OP_LDA, OP_STA, OP_JMP:       return 2'd3;
         default:                      return 2'd1;
      endcase
   endfunction

   // Execute microsteps after fetch; undefined opcodes take none (NOP).
   function automatic logic [1:0] op_steps(input logic [DATA_WIDTH-1:0] op);
      case (op)
         OP_LDI_A, OP_LDI_B, OP_LDI_C, OP_MOV_AB, OP_MOV_AC, OP_MOV_BA,
         OP_MOV_BC, OP_MOV_CA, OP_MOV_CB, OP_JMP:                 return 2'd1;
         OP_INR_A, OP_INR_B, OP_INR_C, OP_DCR_A, OP_DCR_B, OP_DCR_C,
         OP_ADD_B, OP_ADD_C, OP_SUB_B, OP_SUB_C, OP_ANA_B, OP_ANA_C,
         OP_ORA_B, OP_ORA_C, OP_XRA_B, OP_XRA_C, OP_LDA, OP_STA:  return 2'd2;
         default:                                                 return 2'd0;
      endcase
   endfunction
endpackage

module control_unit import arch_defs_pkg::*; (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] opcode,
   output logic [1:0]            byte_idx,
   output logic                  mar_load_c,
   output logic                  fetch_c,
   output logic                  ex0_c,
   output logic                  ex1_c,
   output logic                  halt_set_c
);
   typedef enum logic [2:0] {S_INIT, S_F_ADDR, S_F_WAIT, S_F_LOAD, S_CHK, S_EX0, S_EX1, S_HALT} state_t;
   state_t     state, state_nxt;
   logic [1:0] idx_nxt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_INIT;
         byte_idx <= 2'd0;
      end else begin
         state    <= state_nxt;
         byte_idx <= idx_nxt;
      end
   end

   // byte_idx counts bytes fetched so far for the current instruction.
   always_comb begin
      state_nxt  = state;
      idx_nxt    = byte_idx;
      mar_load_c = 1'b0;
      fetch_c    = 1'b0;
      ex0_c      = 1'b0;
      ex1_c      = 1'b0;
      halt_set_c = 1'b0;
      case (state)
         S_INIT:   begin idx_nxt = 2'd0; state_nxt = S_F_ADDR; end
         S_F_ADDR: begin mar_load_c = 1'b1; state_nxt = S_F_WAIT; end
         S_F_WAIT: state_nxt = S_F_LOAD;
         S_F_LOAD: begin fetch_c = 1'b1; idx_nxt = byte_idx + 2'd1; state_nxt = S_CHK; end
         S_CHK: begin
            if (byte_idx < op_bytes(opcode)) begin
               state_nxt = S_F_ADDR;
            end else begin
               idx_nxt = 2'd0;
               if (opcode == OP_HLT) begin
                  halt_set_c = 1'b1;
                  state_nxt  = S_HALT;
               end else if (op_steps(opcode) == 2'd0) begin
                  state_nxt = S_F_ADDR;
               end else begin
                  state_nxt = S_EX0;
               end
            end
         end
         S_EX0:    begin ex0_c = 1'b1; state_nxt = (op_steps(opcode) == 2'd2) ? S_EX1 : S_F_ADDR; end
         S_EX1:    begin ex1_c = 1'b1; state_nxt = S_F_ADDR; end
         S_HALT:   state_nxt = S_HALT;
         default:  state_nxt = S_INIT;
      endcase
   end
endmodule

module cpu import arch_defs_pkg::*; (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic [ADDR_WIDTH-1:0] mem_addr_c,
   output logic                  wr_en_c,
   output logic [DATA_WIDTH-1:0] wr_data_c
);
   typedef enum logic [2:0] {K_NONE, K_MOV, K_ALU, K_LDA, K_STA, K_JMP} kind_t;
   typedef enum logic [1:0] {R_NONE, R_A, R_B, R_C} dst_t;
   typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_INC, ALU_DEC} alu_t;

   logic [ADDR_WIDTH-1:0] counter_out, mar;
   logic [DATA_WIDTH-1:0] opcode, temp_1_out, temp_2, a_out, b_out, c_out, alu_r;
   logic                  flag_zero_o, flag_negative_o, halt;
   logic [1:0]            byte_idx;
   logic                  mar_load_c, fetch_c, ex0_c, ex1_c, halt_set_c;
   kind_t                 kind;
   dst_t                  dst;
   alu_t                  alu_op;
   logic [DATA_WIDTH-1:0] x, y, alu_res, wb_val;
   logic                  wb_en;

   control_unit u_control_unit (
      .clk(clk), .reset(reset), .opcode(opcode), .byte_idx(byte_idx), .mar_load_c(mar_load_c),
      .fetch_c(fetch_c), .ex0_c(ex0_c), .ex1_c(ex1_c), .halt_set_c(halt_set_c)
   );

   // Instruction decode: operation class, destination register and ALU operands.
   always_comb begin
      kind   = K_NONE;
      dst    = R_NONE;
      alu_op = ALU_ADD;
      x      = a_out;
      y      = b_out;
      case (opcode)
         OP_LDI_A:  begin kind = K_MOV; dst = R_A; x = temp_1_out; end
         OP_LDI_B:  begin kind = K_MOV; dst = R_B; x = temp_1_out; end
         OP_LDI_C:  begin kind = K_MOV; dst = R_C; x = temp_1_out; end
         OP_MOV_AB: begin kind = K_MOV; dst = R_A; x = b_out; end
         OP_MOV_AC: begin kind = K_MOV; dst = R_A; x = c_out; end
         OP_MOV_BA: begin kind = K_MOV; dst = R_B; x = a_out; end
         OP_MOV_BC: begin kind = K_MOV; dst = R_B; x = c_out; end
         OP_MOV_CA: begin kind = K_MOV; dst = R_C; x = a_out; end
         OP_MOV_CB: begin kind = K_MOV; dst = R_C; x = b_out; end
         OP_INR_A:  begin kind = K_ALU; dst = R_A; alu_op = ALU_INC; end
         OP_INR_B:  begin kind = K_ALU; dst = R_B; alu_op = ALU_INC; x = b_out; end
         OP_INR_C:  begin kind = K_ALU; dst = R_C; alu_op = ALU_INC; x = c_out; end
         OP_DCR_A:  begin kind = K_ALU; dst = R_A; alu_op = ALU_DEC; end
         OP_DCR_B:  begin kind = K_ALU; dst = R_B; alu_op = ALU_DEC; x = b_out; end
         OP_DCR_C:  begin kind = K_ALU; dst = R_C; alu_op = ALU_DEC; x = c_out; end
         OP_ADD_B:  begin kind = K_ALU; dst = R_A; alu_op = ALU_ADD; end
         OP_ADD_C:  begin kind = K_ALU; dst = R_A; alu_op = ALU_ADD; y = c_out; end
         OP_SUB_B:  begin kind = K_ALU; dst = R_A; alu_op = ALU_SUB; end
         OP_SUB_C:  begin kind = K_ALU; dst = R_A; alu_op = ALU_SUB; y = c_out; end
         OP_ANA_B:  begin kind = K_ALU; dst = R_A; alu_op = ALU_AND; end
         OP_ANA_C:  begin kind = K_ALU; dst = R_A; alu_op = ALU_AND; y = c_out; end
         OP_ORA_B:  begin kind = K_ALU; dst = R_A; alu_op = ALU_OR; end
         OP_ORA_C:  begin kind = K_ALU; dst = R_A; alu_op = ALU_OR; y = c_out; end
         OP_XRA_B:  begin kind = K_ALU; dst = R_A; alu_op = ALU_XOR; end
         OP_XRA_C:  begin kind = K_ALU; dst = R_A; alu_op = ALU_XOR; y = c_out; end
         OP_LDA:    begin kind = K_LDA; dst = R_A; end
         OP_STA:    kind = K_STA;
         OP_JMP:    kind = K_JMP;
         default:   kind = K_NONE;
      endcase
   end

   always_comb begin
      alu_res = x;
      case (alu_op)
         ALU_ADD: alu_res = x + y;
         ALU_SUB: alu_res = x - y;
         ALU_AND: alu_res = x & y;
         ALU_OR:  alu_res = x | y;
         ALU_XOR: alu_res = x ^ y;
         ALU_INC: alu_res = x + 8'd1;
         default: alu_res = x - 8'd1;
      endcase
   end

   // Direct-address operand drives the bus only during EX0 of LDA/STA; data arrives in EX1.
   always_comb begin
      mem_addr_c = (ex0_c && (kind == K_LDA || kind == K_STA)) ? {temp_2, temp_1_out} : mar;
      wr_en_c    = ex0_c && (kind == K_STA);
      wr_data_c  = a_out;
      wb_en      = (ex0_c && kind == K_MOV) || (ex1_c && (kind == K_ALU || kind == K_LDA));
      wb_val     = ex1_c ? ((kind == K_LDA) ? rd_data : alu_r) : x;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         counter_out     <= ROM_BASE;
         mar             <= '0;
         opcode          <= '0;
         temp_1_out      <= '0;
         temp_2          <= '0;
         a_out           <= '0;
         b_out           <= '0;
         c_out           <= '0;
         alu_r           <= '0;
         flag_zero_o     <= 1'b0;
         flag_negative_o <= 1'b0;
         halt            <= 1'b0;
      end else begin
         if (mar_load_c) mar <= counter_out;
         if (fetch_c) begin
            case (byte_idx)
               2'd0:    opcode     <= rd_data;
               2'd1:    temp_1_out <= rd_data;
               default: temp_2     <= rd_data;
            endcase
            counter_out <= counter_out + 16'd1;
         end
         if (ex0_c) alu_r <= alu_res;
         if (ex0_c && kind == K_JMP) counter_out <= {temp_2, temp_1_out};
         if (wb_en) begin
            case (dst)
               R_A:     a_out <= wb_val;
               R_B:     b_out <= wb_val;
               R_C:     c_out <= wb_val;
               default: ;
            endcase
         end
         if (ex1_c && kind == K_ALU) begin
            flag_zero_o     <= (alu_r == 8'h00);
            flag_negative_o <= alu_r[7];
         end
         if (halt_set_c) halt <= 1'b1;
      end
   end
endmodule

module ram import arch_defs_pkg::*; (
   input  logic                  clk,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] q
);
   logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
   logic                  hit;

   assign hit = (addr[15:12] == 4'h0);

   // Synchronous read; addresses outside RAM read as zero so the bus can OR both memories.
   always_ff @(posedge clk) begin
      if (wr_en && hit) mem[addr[11:0]] <= wr_data;
      q <= hit ? mem[addr[11:0]] : 8'h00;
   end

   task automatic init_sim_ram(input logic [11:0] a, input logic [DATA_WIDTH-1:0] d);
      mem[a] <= d;
   endtask
endmodule

module rom import arch_defs_pkg::*; (
   input  logic                  clk,
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic [DATA_WIDTH-1:0] q
);
   logic [DATA_WIDTH-1:0] mem [ROM_DEPTH];

   always_ff @(posedge clk) q <= (addr[15:12] == 4'hF) ? mem[addr[11:0]] : 8'h00;

   task automatic init_sim_rom(input logic [11:0] a, input logic [DATA_WIDTH-1:0] d);
      mem[a] <= d;
   endtask

   task automatic dump(input logic [11:0] a, output logic [DATA_WIDTH-1:0] d);
      d = mem[a];
   endtask
endmodule

module computer_top import arch_defs_pkg::*; (
   input logic clk,
   input logic reset
);
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] wr_data, rd_data, ram_q, rom_q;
   logic                  wr_en;

   cpu u_cpu (
      .clk(clk), .reset(reset), .rd_data(rd_data),
      .mem_addr_c(mem_addr), .wr_en_c(wr_en), .wr_data_c(wr_data)
   );

   ram u_ram (.clk(clk), .addr(mem_addr), .wr_en(wr_en), .wr_data(wr_data), .q(ram_q));
   rom u_rom (.clk(clk), .addr(mem_addr), .q(rom_q));

   assign rd_data = ram_q | rom_q;
endmodule

// File: tb/tb_computer_top.sv
// Scoreboard bench for computer_top: directed ROM programs, expectations queued with the edge (or halt) they are due at.
module tb_computer_top;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   computer_top dut (.clk(clk), .reset(reset));

   localparam int P_OPC = 0, P_CUOPC = 1, P_T1 = 2, P_A = 3, P_B = 4, P_C = 5;
   localparam int P_PC = 6, P_Z = 7, P_N = 8, P_HALT = 9, P_RAM10 = 10;

   typedef struct {
      string       name;
      int          at;
      bit          on_halt;
      int          probe;
      logic [15:0] exp;
   } exp_t;

   exp_t       sb[$];
   int         checks = 0;
   int         failures = 0;
   int         edge_cnt = 0;
   logic [7:0] prog[$];

   // Rising edges since the last reset release.
   always @(posedge clk or negedge reset)
      if (!reset) edge_cnt <= 0;
      else        edge_cnt <= edge_cnt + 1;

   function automatic logic [15:0] probe(input int p);
      case (p)
         P_OPC:   probe = {8'h00, dut.u_cpu.opcode};
         P_CUOPC: probe = {8'h00, dut.u_cpu.u_control_unit.opcode};
         P_T1:    probe = {8'h00, dut.u_cpu.temp_1_out};
         P_A:     probe = {8'h00, dut.u_cpu.a_out};
         P_B:     probe = {8'h00, dut.u_cpu.b_out};
         P_C:     probe = {8'h00, dut.u_cpu.c_out};
         P_PC:    probe = dut.u_cpu.counter_out;
         P_Z:     probe = {15'h0, dut.u_cpu.flag_zero_o};
         P_N:     probe = {15'h0, dut.u_cpu.flag_negative_o};
         P_HALT:  probe = {15'h0, dut.u_cpu.halt};
         P_RAM10: probe = {8'h00, dut.u_ram.mem[16]};
         default: probe = 16'hDEAD;
      endcase
   endfunction

   // Monitor: pops every expectation that has come due and compares it with the probed state.
   always @(negedge clk) begin
      exp_t it;
      while (sb.size() > 0 &&
             (sb[0].on_halt ? (dut.u_cpu.halt || edge_cnt >= sb[0].at) : (edge_cnt >= sb[0].at))) begin
         it = sb.pop_front();
         checks++;
         if (it.on_halt && !dut.u_cpu.halt) begin
            failures++;
            $display("FAIL %s: halt not reached by edge %0d", it.name, it.at);
         end else if (probe(it.probe) !== it.exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (edge %0d)", it.name, probe(it.probe), it.exp, edge_cnt);
         end
      end
   end

   task automatic sync();
      @(negedge clk);
      #2;
   endtask

   task automatic expect_at(input string name, input int at, input int p, input logic [15:0] e);
      exp_t it;
      it.name = name; it.at = at; it.on_halt = 1'b0; it.probe = p; it.exp = e;
      sb.push_back(it);
   endtask

   task automatic expect_halt(input string name, input int p, input logic [15:0] e);
      exp_t it;
      it.name = name; it.at = 100; it.on_halt = 1'b1; it.probe = p; it.exp = e;
      sb.push_back(it);
   endtask

   // Hold reset, load prog into ROM 0xF000.., clear RAM[0x10], check the reset state.
   task automatic begin_test(input string name);
      reset = 1'b0;
      sync();
      for (int i = 0; i < 16; i++)
         dut.u_rom.init_sim_rom(12'(i), (i < prog.size()) ? prog[i] : 8'h00);
      dut.u_ram.init_sim_ram(12'h010, 8'h00);
      expect_at({name, "_rst_pc"}, 0, P_PC, 16'hF000);
      expect_at({name, "_rst_b"}, 0, P_B, 16'h0000);
      expect_at({name, "_rst_halt"}, 0, P_HALT, 16'h0000);
      sync();
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (sb.size() > 0 && n < 300) begin
         sync();
         n++;
      end
      if (sb.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL %s: %0d expectations outstanding after %0d cycles", name, sb.size(), n);
         sb.delete();
      end
   endtask

   initial begin
      reset = 1'b1;
      #1;

      // LDI_B 01 / INR_B / HLT with edge-exact timing.
      prog = '{8'h06, 8'h01, 8'h04, 8'h76};
      begin_test("t1");
      expect_at("t1_op_ldi", 5, P_OPC, 16'h0006);
      expect_at("t1_temp1", 9, P_T1, 16'h0001);
      expect_at("t1_b_ldi", 11, P_B, 16'h0001);
      expect_at("t1_z_ldi", 11, P_Z, 16'h0000);
      expect_at("t1_n_ldi", 11, P_N, 16'h0000);
      expect_at("t1_op_inr", 14, P_OPC, 16'h0004);
      expect_at("t1_b_inr", 17, P_B, 16'h0002);
      expect_at("t1_z_inr", 17, P_Z, 16'h0000);
      expect_at("t1_n_inr", 17, P_N, 16'h0000);
      expect_at("t1_nohalt", 19, P_HALT, 16'h0000);
      expect_at("t1_cu_op", 20, P_CUOPC, 16'h0076);
      expect_at("t1_pc_hlt", 20, P_PC, 16'hF004);
      expect_at("t1_halt", 20, P_HALT, 16'h0001);
      expect_halt("t1_halt_pc", P_PC, 16'hF004);
      expect_halt("t1_halt_op", P_OPC, 16'h0076);
      reset = 1'b1;
      wait_done("t1");

      // INR wraps FF -> 00.
      prog = '{8'h06, 8'hFF, 8'h04, 8'h76};
      begin_test("t2");
      expect_halt("t2_b", P_B, 16'h0000);
      expect_halt("t2_z", P_Z, 16'h0001);
      expect_halt("t2_n", P_N, 16'h0000);
      reset = 1'b1;
      wait_done("t2");

      // DCR wraps 00 -> FF.
      prog = '{8'h06, 8'h00, 8'h05, 8'h76};
      begin_test("t3");
      expect_halt("t3_b", P_B, 16'h00FF);
      expect_halt("t3_z", P_Z, 16'h0000);
      expect_halt("t3_n", P_N, 16'h0001);
      reset = 1'b1;
      wait_done("t3");

      // STA/LDA round trip through RAM 0x0010.
      prog = '{8'h3E, 8'h05, 8'h32, 8'h10, 8'h00, 8'h3A, 8'h10, 8'h00, 8'h76};
      begin_test("t4");
      expect_halt("t4_ram", P_RAM10, 16'h0005);
      expect_halt("t4_a", P_A, 16'h0005);
      expect_halt("t4_pc", P_PC, 16'hF009);
      expect_halt("t4_z", P_Z, 16'h0000);
      reset = 1'b1;
      wait_done("t4");

      // Reset between INR_B's two microsteps, then full rerun.
      prog = '{8'h06, 8'h01, 8'h04, 8'h76};
      begin_test("t5");
      expect_at("t5_b_ldi", 11, P_B, 16'h0001);
      reset = 1'b1;
      begin
         int n = 0;
         while (edge_cnt < 15 && n < 100) begin sync(); n++; end
      end
      expect_at("t5_mid_pc", 0, P_PC, 16'hF000);
      expect_at("t5_mid_b", 0, P_B, 16'h0000);
      expect_at("t5_mid_op", 0, P_OPC, 16'h0000);
      expect_at("t5_mid_t1", 0, P_T1, 16'h0000);
      reset = 1'b0;
      sync();
      sync();
      expect_halt("t5_rerun_b", P_B, 16'h0002);
      expect_halt("t5_rerun_pc", P_PC, 16'hF004);
      reset = 1'b1;
      wait_done("t5");

      // JMP over an HLT.
      prog = '{8'hC3, 8'h04, 8'hF0, 8'h76, 8'h0E, 8'h07, 8'h76};
      begin_test("t6");
      expect_halt("t6_c", P_C, 16'h0007);
      expect_halt("t6_pc", P_PC, 16'hF007);
      reset = 1'b1;
      wait_done("t6");

      // Undefined opcode ED is a zero-step NOP: halt lands at edge 1+9+4+6+4 = 24.
      prog = '{8'h06, 8'h03, 8'hED, 8'h05, 8'h76};
      begin_test("t7");
      expect_at("t7_nohalt", 23, P_HALT, 16'h0000);
      expect_at("t7_halt", 24, P_HALT, 16'h0001);
      expect_halt("t7_b", P_B, 16'h0002);
      expect_halt("t7_pc", P_PC, 16'hF005);
      reset = 1'b1;
      wait_done("t7");

      // SUB_B to zero.
      prog = '{8'h3E, 8'h05, 8'h06, 8'h05, 8'h90, 8'h76};
      begin_test("t8");
      expect_halt("t8_a", P_A, 16'h0000);
      expect_halt("t8_z", P_Z, 16'h0001);
      reset = 1'b1;
      wait_done("t8");

      // ANA_C F0&3C=30 then XRA_C 30^3C=0C.
      prog = '{8'h3E, 8'hF0, 8'h0E, 8'h3C, 8'hA1, 8'hA9, 8'h76};
      begin_test("t9");
      expect_halt("t9_a", P_A, 16'h000C);
      expect_halt("t9_n", P_N, 16'h0000);
      reset = 1'b1;
      wait_done("t9");

      // MOV A,B leaves flags alone.
      prog = '{8'h06, 8'h81, 8'h78, 8'h76};
      begin_test("t10");
      expect_halt("t10_a", P_A, 16'h0081);
      expect_halt("t10_n", P_N, 16'h0000);
      reset = 1'b1;
      wait_done("t10");

      // ADD_B 0C+0A=16, ORA_C 16|F3=F7 (negative).
      prog = '{8'h3E, 8'h0C, 8'h06, 8'h0A, 8'h80, 8'h0E, 8'hF3, 8'hB1, 8'h76};
      begin_test("t11");
      expect_halt("t11_a", P_A, 16'h00F7);
      expect_halt("t11_n", P_N, 16'h0001);
      expect_halt("t11_z", P_Z, 16'h0000);
      reset = 1'b1;
      wait_done("t11");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
